// File: rtl/sauria_cfg_sequencer_if.sv
// Command, response and AXI4-Lite configuration bundle for sauria_cfg_sequencer.
// "master" is the sequencer's view; "slave" is the view of the host and the cfg AXI slave.
interface sauria_cfg_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // host command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_data;
    logic [DATA_W/8-1:0]   cmd_strb;
    // host response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;
    // AXI4-Lite configuration port
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_strb, rsp_ready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_timeout,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_strb, rsp_ready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_timeout,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready
    );
endinterface

// File: rtl/sauria_cfg_sequencer.sv
// Single-outstanding command sequencer driving SAURIA's AXI4-Lite configuration port.
// Each accepted command (WRITE, READ, WAIT_INTR, NOP) produces exactly one response.
module sauria_cfg_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TMO_W      = 20,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic                  i_system_clk,
    input  logic                  i_system_rstn,
    input  logic                  i_intr,
    output logic                  o_busy,
    sauria_cfg_sequencer_if.master cfg_if
);
    localparam int               STRB_W   = DATA_W / 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_WAIT_INTR, S_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;
    logic                intr_q;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_tmo_q, rsp_tmo_d;
    logic                aw_ok, w_ok;

    // State and datapath registers; intr_q samples the interrupt every cycle for edge detection
    always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
        if (!i_system_rstn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            cnt_q      <= '0;
            intr_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_resp_q <= 2'b00;
            rsp_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            cnt_q      <= cnt_d;
            intr_q     <= i_intr;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
            rsp_tmo_q  <= rsp_tmo_d;
        end
    end

    // AW and W complete independently; WR ends once both handshakes have happened
    assign aw_ok = aw_done_q || cfg_if.awready;
    assign w_ok  = w_done_q  || cfg_if.wready;

    // Next-state logic and response capture
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        rsp_tmo_d  = rsp_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_if.cmd_valid) begin
                    addr_d     = cfg_if.cmd_addr;
                    wdata_d    = cfg_if.cmd_data;
                    strb_d     = cfg_if.cmd_strb;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    cnt_d      = '0;
                    rsp_data_d = '0;
                    rsp_resp_d = 2'b00;
                    rsp_tmo_d  = 1'b0;
                    case (cfg_if.cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD_AR;
                        OP_WAIT:  state_d = S_WAIT_INTR;
                        OP_NOP:   state_d = S_RSP;
                        default:  state_d = S_RSP;
                    endcase
                end
            end
            S_WR: begin
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok && w_ok) begin
                    state_d = S_WR_B;
                end
            end
            S_WR_B: begin
                if (cfg_if.bvalid) begin
                    rsp_resp_d = cfg_if.bresp;
                    state_d    = S_RSP;
                end
            end
            S_RD_AR: begin
                if (cfg_if.arready) begin
                    state_d = S_RD_R;
                end
            end
            S_RD_R: begin
                if (cfg_if.rvalid) begin
                    rsp_data_d = cfg_if.rdata;
                    rsp_resp_d = cfg_if.rresp;
                    state_d    = S_RSP;
                end
            end
            S_WAIT_INTR: begin
                cnt_d = cnt_q + TMO_W'(1);
                // a fresh edge takes priority over expiry in the same cycle
                if (i_intr && !intr_q) begin
                    state_d = S_RSP;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_resp_d = 2'b10;
                    rsp_tmo_d  = 1'b1;
                    state_d    = S_RSP;
                end
            end
            S_RSP: begin
                if (cfg_if.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_if.cmd_ready   = (state_q == S_IDLE);
    assign o_busy             = (state_q != S_IDLE);
    assign cfg_if.rsp_valid   = (state_q == S_RSP);
    assign cfg_if.rsp_data    = rsp_data_q;
    assign cfg_if.rsp_resp    = rsp_resp_q;
    assign cfg_if.rsp_timeout = rsp_tmo_q;

    assign cfg_if.awaddr  = addr_q;
    assign cfg_if.awprot  = 3'b000;
    assign cfg_if.awvalid = (state_q == S_WR) && !aw_done_q;
    assign cfg_if.wdata   = wdata_q;
    assign cfg_if.wstrb   = strb_q;
    assign cfg_if.wvalid  = (state_q == S_WR) && !w_done_q;
    assign cfg_if.bready  = (state_q == S_WR_B);
    assign cfg_if.araddr  = addr_q;
    assign cfg_if.arprot  = 3'b000;
    assign cfg_if.arvalid = (state_q == S_RD_AR);
    assign cfg_if.rready  = (state_q == S_RD_R);
endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// Bench for sauria_cfg_sequencer: directed scenarios followed by randomized commands against
// an AXI4-Lite slave model with random per-channel delays and a cycle-level latency model.
module tb_sauria_cfg_sequencer;
    localparam int TMO = 16;
    localparam logic [1:0] OP_WRITE = 2'b00, OP_READ = 2'b01, OP_WAIT = 2'b10, OP_NOP = 2'b11;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic intr = 1'b0;
    logic busy;

    sauria_cfg_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sauria_cfg_sequencer #(.ADDR_W(32), .DATA_W(32), .TMO_W(20), .TMO_CYCLES(TMO)) dut (
        .i_system_clk (clk),
        .i_system_rstn(rstn),
        .i_intr       (intr),
        .o_busy       (busy),
        .cfg_if       (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // slave configuration and observations
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = '0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int          aw_hi = 0, w_hi = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Count cycles each write valid is high, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (bus.awvalid === 1'b1) aw_hi++;
        if (bus.wvalid === 1'b1) w_hi++;
    end

    // AW slave: ready after aw_dly cycles of valid
    initial begin
        bus.awready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.awvalid === 1'b1) begin
                for (int k = 0; k < aw_dly && bus.awvalid === 1'b1; k++) begin @(posedge clk); #1; end
                if (bus.awvalid === 1'b1) begin
                    bus.awready = 1'b1; last_awaddr = bus.awaddr; aw_cnt++;
                    @(posedge clk); #1 bus.awready = 1'b0;
                end
            end
        end
    end

    // W slave
    initial begin
        bus.wready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.wvalid === 1'b1) begin
                for (int k = 0; k < w_dly && bus.wvalid === 1'b1; k++) begin @(posedge clk); #1; end
                if (bus.wvalid === 1'b1) begin
                    bus.wready = 1'b1; last_wdata = bus.wdata; last_wstrb = bus.wstrb; w_cnt++;
                    @(posedge clk); #1 bus.wready = 1'b0;
                end
            end
        end
    end

    // B slave: bvalid b_dly cycles after bready is seen
    initial begin
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (bus.bready === 1'b1) begin
                for (int k = 0; k < b_dly && bus.bready === 1'b1; k++) begin @(posedge clk); #1; end
                if (bus.bready === 1'b1) begin
                    bus.bvalid = 1'b1; bus.bresp = bresp_v;
                    @(posedge clk); #1 bus.bvalid = 1'b0; bus.bresp = 2'b00;
                end
            end
        end
    end

    // AR slave
    initial begin
        bus.arready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.arvalid === 1'b1) begin
                for (int k = 0; k < ar_dly && bus.arvalid === 1'b1; k++) begin @(posedge clk); #1; end
                if (bus.arvalid === 1'b1) begin
                    bus.arready = 1'b1; last_araddr = bus.araddr; ar_cnt++;
                    @(posedge clk); #1 bus.arready = 1'b0;
                end
            end
        end
    end

    // R slave
    initial begin
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (bus.rready === 1'b1) begin
                for (int k = 0; k < r_dly && bus.rready === 1'b1; k++) begin @(posedge clk); #1; end
                if (bus.rready === 1'b1) begin
                    bus.rvalid = 1'b1; bus.rdata = rdata_v; bus.rresp = rresp_v;
                    @(posedge clk); #1 bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a command (caller is 1 time unit after a rising edge); returns 1 unit after the accept edge
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        int guard = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr;
        bus.cmd_data = data; bus.cmd_strb = strb;
        while (bus.cmd_ready !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
        chk("cmd_accept_in_time", (guard < 200), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Cycles from acceptance until rsp_valid is visible (1 = first cycle after accept)
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    // Hold rsp_ready low for 'hold' cycles checking the response stays put, then consume it
    task automatic consume(input string tag, input int hold, input logic [31:0] ed,
                           input logic [1:0] er, input logic et);
        chk({tag, "_data"}, bus.rsp_data, ed);
        chk({tag, "_resp"}, bus.rsp_resp, er);
        chk({tag, "_tmo"}, bus.rsp_timeout, et);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, bus.rsp_valid, 1);
            chk({tag, "_hold_data"}, bus.rsp_data, ed);
            chk({tag, "_hold_resp"}, bus.rsp_resp, er);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_valid_clear"}, bus.rsp_valid, 0);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int hold,
                           input int exp_lat, input logic [31:0] ed, input logic [1:0] er,
                           input logic et);
        int lat;
        issue(op, addr, data, strb);
        wait_rsp(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        consume(tag, hold, ed, er, et);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        int a0, w0, r0, lat, el;
        logic [1:0]  op;
        logic [31:0] addr, data;
        logic [3:0]  strb;
        int hold;

        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0;
        bus.cmd_data = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b0;

        // reset values
        #1;
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_prot", {bus.awprot, bus.arprot}, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        step(1);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // 1: best-case write
        a0 = aw_cnt; w0 = w_cnt; aw_hi = 0; w_hi = 0;
        run_cmd("t1_write", OP_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 3, 32'h0, 2'b00, 1'b0);
        chk("t1_aw_count", aw_cnt - a0, 1);
        chk("t1_w_count", w_cnt - w0, 1);
        chk("t1_awaddr", last_awaddr, 32'h0000_0010);
        chk("t1_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("t1_wstrb", last_wstrb, 4'hF);

        // 2: awready at +1, wready at +4
        aw_dly = 0; w_dly = 3; bresp_v = 2'b00;
        a0 = aw_cnt; w0 = w_cnt; aw_hi = 0; w_hi = 0;
        run_cmd("t2_write", OP_WRITE, 32'h0000_0014, 32'h0BAD_F00D, 4'h3, 0, 6, 32'h0, 2'b00, 1'b0);
        chk("t2_aw_count", aw_cnt - a0, 1);
        chk("t2_w_count", w_cnt - w0, 1);
        chk("t2_awvalid_cycles", aw_hi, 1);
        chk("t2_wvalid_cycles", w_hi, 4);
        w_dly = 0;

        // 3: read with 3-cycle rvalid delay and SLVERR
        r_dly = 3; rdata_v = 32'h1234_5678; rresp_v = 2'b10; r0 = ar_cnt;
        run_cmd("t3_read", OP_READ, 32'h0000_0020, 32'h0, 4'h0, 1, 6, 32'h1234_5678, 2'b10, 1'b0);
        chk("t3_ar_count", ar_cnt - r0, 1);
        chk("t3_araddr", last_araddr, 32'h0000_0020);
        r_dly = 0;

        // 4: interrupt level already high at entry must not complete the wait
        intr = 1'b1;
        step(2);
        issue(OP_WAIT, 32'h0, 32'h0, 4'h0);          // now in first WAIT_INTR cycle (E)
        chk("t4_busy", busy, 1);
        step(5); intr = 1'b0;                        // E+5
        chk("t4_no_rsp_stale", bus.rsp_valid, 0);
        step(4); intr = 1'b1;                        // E+9: rising edge
        chk("t4_no_rsp_before_edge", bus.rsp_valid, 0);
        step(1);                                     // response the cycle after the edge is seen
        chk("t4_rsp_valid", bus.rsp_valid, 1);
        consume("t4_wait", 0, 32'h0, 2'b00, 1'b0);
        intr = 1'b0;

        // 5: timeout, then edge coinciding with expiry, then NOP
        step(1);
        run_cmd("t5_tmo", OP_WAIT, 32'h0, 32'h0, 4'h0, 0, TMO + 1, 32'h0, 2'b10, 1'b1);
        issue(OP_WAIT, 32'h0, 32'h0, 4'h0);
        step(TMO - 1); intr = 1'b1;                  // last count cycle
        chk("t5b_no_rsp_yet", bus.rsp_valid, 0);
        step(1);
        chk("t5b_rsp_valid", bus.rsp_valid, 1);
        consume("t5b_edge_wins", 0, 32'h0, 2'b00, 1'b0);
        intr = 1'b0;
        run_cmd("t5_nop", OP_NOP, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 2'b00, 1'b0);

        // 6: held response with a pending command, then reset during WR
        aw_dly = 20; w_dly = 0;
        issue(OP_NOP, 32'h0, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t6_nop_lat", lat, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_addr = 32'h40;
        bus.cmd_data = 32'hA5A5_A5A5; bus.cmd_strb = 4'hF;
        for (int h = 0; h < 5; h++) begin
            chk("t6_hold_rsp_valid", bus.rsp_valid, 1);
            chk("t6_hold_cmd_ready", bus.cmd_ready, 0);
            chk("t6_hold_resp", bus.rsp_resp, 2'b00);
            step(1);
        end
        bus.rsp_ready = 1'b1;
        chk("t6_cmd_ready_at_hs", bus.cmd_ready, 0);
        step(1);
        bus.rsp_ready = 1'b0;
        chk("t6_rsp_cleared", bus.rsp_valid, 0);
        chk("t6_cmd_ready_after", bus.cmd_ready, 1);
        a0 = aw_cnt;
        step(1);
        bus.cmd_valid = 1'b0;
        chk("t6_wr_awvalid", bus.awvalid, 1);
        step(2);
        chk("t6_wr_still_waiting", bus.awvalid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_awvalid", bus.awvalid, 0);
        chk("t6_rst_wvalid", bus.wvalid, 0);
        chk("t6_rst_bready", bus.bready, 0);
        chk("t6_rst_arvalid", bus.arvalid, 0);
        chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rst_busy", busy, 0);
        @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
        step(1);
        chk("t6_idle_cmd_ready", bus.cmd_ready, 1);
        chk("t6_idle_busy", busy, 0);
        step(25);
        chk("t6_no_aw_after_rst", aw_cnt - a0, 0);
        aw_dly = 0;
        run_cmd("t6_recover_nop", OP_NOP, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 2'b00, 1'b0);

        // randomized commands against the slave model
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_WRITE;
                1:       op = OP_READ;
                default: op = OP_NOP;
            endcase
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            bresp_v = 2'($urandom_range(0, 3)); rresp_v = 2'($urandom_range(0, 3));
            rdata_v = $urandom;
            addr = $urandom & 32'hFFFF_FFFC; data = $urandom; strb = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 2);
            a0 = aw_cnt; w0 = w_cnt; r0 = ar_cnt; aw_hi = 0; w_hi = 0;
            if (op == OP_WRITE) begin
                el = 3 + max2(aw_dly, w_dly) + b_dly;
                run_cmd("rnd_write", op, addr, data, strb, hold, el, 32'h0, bresp_v, 1'b0);
                chk("rnd_aw_count", aw_cnt - a0, 1);
                chk("rnd_w_count", w_cnt - w0, 1);
                chk("rnd_awaddr", last_awaddr, addr);
                chk("rnd_wdata", last_wdata, data);
                chk("rnd_wstrb", last_wstrb, strb);
                chk("rnd_awvalid_cycles", aw_hi, aw_dly + 1);
                chk("rnd_wvalid_cycles", w_hi, w_dly + 1);
            end else if (op == OP_READ) begin
                el = 3 + ar_dly + r_dly;
                run_cmd("rnd_read", op, addr, data, strb, hold, el, rdata_v, rresp_v, 1'b0);
                chk("rnd_ar_count", ar_cnt - r0, 1);
                chk("rnd_araddr", last_araddr, addr);
            end else begin
                run_cmd("rnd_nop", op, addr, data, strb, hold, 1, 32'h0, 2'b00, 1'b0);
                chk("rnd_nop_no_bus", (aw_cnt - a0) + (w_cnt - w0) + (ar_cnt - r0), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
